iconn_arbiter: RTL and testbench
================================

ICONN_ARBITER -- requirements
Module: iconn_arbiter

Interface
REQ-001 SHALL have parameter PORT_NUM, default 4, number of input ports; legal range 2..16.
REQ-002 SHALL have parameter NODE_ADDR_WIDTH, default 5, width of each node address.
REQ-003 SHALL have parameter ARB_MODE, default ARB_RR, arbitration mode: ARB_FIXED (port 0 highest) or ARB_RR (round-robin).
REQ-004 SHALL define IDX_W = max(1, clog2(PORT_NUM)).
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port ain  input  PORT_NUM x NODE_ADDR_WIDTH  per-port node address.
REQ-008 SHALL have port ain_valid  input  PORT_NUM  per-port request valid.
REQ-009 SHALL have port ain_ready  output  PORT_NUM  per-port accept; at most one bit high.
REQ-010 SHALL have port aout  output  NODE_ADDR_WIDTH  registered address of the granted request.
REQ-011 SHALL have port aout_valid  output  1  output register holds data.
REQ-012 SHALL have port aout_ready  input  1  downstream accept.
REQ-013 SHALL have port port_index  output  IDX_W  registered source port of aout.

Function
REQ-014 SHALL contain one output register stage (aout, port_index, aout_valid); ain-to-aout latency exactly 1 cycle.
REQ-015 SHALL define load = !aout_valid || aout_ready; ain_ready[i] high only when load, ain_valid[i], and i is the winner.
REQ-016 SHALL transfer port i when ain_valid[i] && ain_ready[i]; next cycle aout = ain[i], port_index = i, aout_valid = 1.
REQ-017 SHALL, in ARB_FIXED, pick the lowest-index valid port.
REQ-018 SHALL, in ARB_RR, search from pointer rr_ptr upward with wrap at PORT_NUM-1 to 0, picking the first valid port.
REQ-019 SHALL update rr_ptr to (winner+1) mod PORT_NUM only on a transfer; non-power-of-2 PORT_NUM wraps to 0, never to an unused index.
REQ-020 SHALL leave rr_ptr unchanged when no port is valid or load is low.
REQ-021 SHALL hold aout, port_index stable while aout_valid && !aout_ready.
REQ-022 SHALL clear aout_valid when aout_ready && aout_valid and no transfer occurs in the same cycle.
REQ-023 SHALL, on simultaneous drain and transfer, load the new request with aout_valid staying 1 (no bubble).
REQ-024 SHALL not depend combinationally of ain_ready on aout_ready beyond the load term; no combinational path from ain to aout.
REQ-025 SHALL sustain one transfer per cycle when aout_ready is held high.

Reset
REQ-026 SHALL, on rst_n low, immediately set aout_valid=0, aout=0, port_index=0, rr_ptr=0.
REQ-027 SHALL drive ain_ready all-zero during reset.
REQ-028 SHALL discard any held output on reset mid-operation; first grant after release follows rr_ptr=0.

Structure
REQ-029 SHALL place enum arb_mode_e {ARB_FIXED, ARB_RR} in shared package iconn_pkg.
REQ-030 SHALL implement winner selection in combinational sub-module iconn_rr_pick (inputs valid vector, start pointer; outputs winner index, any_valid); ARB_FIXED drives start pointer 0.

Verification
REQ-031 SHALL cover: PORT_NUM=4, ARB_FIXED, ports 1 and 3 valid, aout_ready=1 -> port 1 granted every cycle, port 3 starved, port_index=1.
REQ-032 SHALL cover: PORT_NUM=4, ARB_RR, all ports valid, aout_ready=1 -> port_index sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 SHALL cover: PORT_NUM=3, ARB_RR, all valid -> sequence 0,1,2,0; rr_ptr never 3.
REQ-034 SHALL cover: aout_valid=1, aout_ready=0 for 5 cycles -> aout/port_index unchanged, ain_ready all-zero; aout_ready=1 -> next request loaded same cycle, no bubble.
REQ-035 SHALL cover: rst_n asserted mid-stream with aout_valid=1 -> outputs zero without clock edge; after release all-valid -> first grant port 0.

Source files
------------

// File: rtl/iconn_pkg.sv
// Shared types and helpers for the interconnect arbiter slice.
package iconn_pkg;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_e;

    // Index width for n ports, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iconn_rr_pick.sv
// Combinational winner search: first valid port at or above start, wrapping to port 0.
module iconn_rr_pick #(
    parameter int PORT_NUM = 4,
    parameter int IDX_W    = 2
) (
    input  logic [PORT_NUM-1:0] valid,
    input  logic [IDX_W-1:0]    start,
    output logic [IDX_W-1:0]    winner,
    output logic                any_valid
);

    logic [IDX_W-1:0] hi_win;
    logic [IDX_W-1:0] lo_win;
    logic             hi_hit;

    // Descending scans let the lowest qualifying index overwrite the rest, so the
    // upper segment [start..PORT_NUM-1] takes precedence over the wrapped one.
    // NOTE: every comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        hi_win = '0;
        lo_win = '0;
        hi_hit = 1'b0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            if (valid[i]) begin
                lo_win = IDX_W'(i);
                if (i >= int'(start)) begin
                    hi_win = IDX_W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
    end

    assign winner    = hi_hit ? hi_win : lo_win;
    assign any_valid = |valid;

endmodule

// File: rtl/iconn_arbiter.sv
// N-to-1 address arbiter with fixed or round-robin priority and one registered output stage.
module iconn_arbiter
    import iconn_pkg::*;
#(
    parameter int        PORT_NUM        = 4,
    parameter int        NODE_ADDR_WIDTH = 5,
    parameter arb_mode_e ARB_MODE        = ARB_RR,
    localparam int       IDX_W           = idx_width(PORT_NUM)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [PORT_NUM-1:0][NODE_ADDR_WIDTH-1:0] ain,
    input  logic [PORT_NUM-1:0]                      ain_valid,
    output logic [PORT_NUM-1:0]                      ain_ready,
    output logic [NODE_ADDR_WIDTH-1:0]               aout,
    output logic                                     aout_valid,
    input  logic                                     aout_ready,
    output logic [IDX_W-1:0]                         port_index
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] rr_next;
    logic             any_valid;
    logic             load;
    logic             xfer;

    assign start = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr;

    iconn_rr_pick #(
        .PORT_NUM (PORT_NUM),
        .IDX_W    (IDX_W)
    ) u_pick (
        .valid     (ain_valid),
        .start     (start),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // The register can accept whenever it is empty or being drained this cycle.
    // rst_n gates the handshake so no port sees ready while reset is held.
    assign load    = !aout_valid || aout_ready;
    assign xfer    = load && any_valid && rst_n;
    assign rr_next = (winner == IDX_W'(PORT_NUM - 1)) ? '0 : winner + IDX_W'(1);

    always_comb begin
        ain_ready = '0;
        if (xfer) ain_ready[winner] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aout       <= '0;
            port_index <= '0;
            aout_valid <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            if (xfer) begin
                aout       <= ain[winner];
                port_index <= winner;
                aout_valid <= 1'b1;
                rr_ptr     <= rr_next;
            end else if (aout_ready) begin
                aout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iconn_arbiter.sv
// Directed bench: fixed and round-robin arbiters (4 and 3 ports), stall, drain and async reset.
module tb_iconn_arbiter;
    import iconn_pkg::*;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;

    // Fixed-priority, 4 ports
    logic [3:0][AW-1:0] fx_ain;
    logic [3:0]         fx_valid, fx_ready;
    logic [AW-1:0]      fx_aout;
    logic               fx_ovalid, fx_oready;
    logic [1:0]         fx_idx;

    // Round-robin, 4 ports
    logic [3:0][AW-1:0] rr_ain;
    logic [3:0]         rr_valid, rr_ready;
    logic [AW-1:0]      rr_aout;
    logic               rr_ovalid, rr_oready;
    logic [1:0]         rr_idx;

    // Round-robin, 3 ports
    logic [2:0][AW-1:0] r3_ain;
    logic [2:0]         r3_valid, r3_ready;
    logic [AW-1:0]      r3_aout;
    logic               r3_ovalid, r3_oready;
    logic [1:0]         r3_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iconn_arbiter #(.PORT_NUM(4), .NODE_ADDR_WIDTH(AW), .ARB_MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n), .ain(fx_ain), .ain_valid(fx_valid), .ain_ready(fx_ready),
        .aout(fx_aout), .aout_valid(fx_ovalid), .aout_ready(fx_oready), .port_index(fx_idx)
    );

    iconn_arbiter #(.PORT_NUM(4), .NODE_ADDR_WIDTH(AW), .ARB_MODE(ARB_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n), .ain(rr_ain), .ain_valid(rr_valid), .ain_ready(rr_ready),
        .aout(rr_aout), .aout_valid(rr_ovalid), .aout_ready(rr_oready), .port_index(rr_idx)
    );

    iconn_arbiter #(.PORT_NUM(3), .NODE_ADDR_WIDTH(AW), .ARB_MODE(ARB_RR)) dut_r3 (
        .clk(clk), .rst_n(rst_n), .ain(r3_ain), .ain_valid(r3_valid), .ain_ready(r3_ready),
        .aout(r3_aout), .aout_valid(r3_ovalid), .aout_ready(r3_oready), .port_index(r3_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected grant orders worked out by hand from the round-robin rule.
    int seq4 [5] = '{0, 1, 2, 3, 0};
    int seq3 [5] = '{0, 1, 2, 0, 1};
    int ptr3 [5] = '{1, 2, 0, 1, 2};

    initial begin
        for (int i = 0; i < 4; i++) begin
            fx_ain[i] = AW'(8'h10 + i);
            rr_ain[i] = AW'(8'h10 + i);
        end
        for (int i = 0; i < 3; i++) r3_ain[i] = AW'(8'h08 + i);
        fx_valid = 4'b1010; fx_oready = 1'b1;
        rr_valid = 4'b1111; rr_oready = 1'b1;
        r3_valid = 3'b111;  r3_oready = 1'b1;
        rst_n    = 1'b0;

        // Reset state, with every port requesting.
        #1;
        check("reset_rr_aout_valid", rr_ovalid, 0);
        check("reset_rr_aout", rr_aout, 0);
        check("reset_rr_port_index", rr_idx, 0);
        check("reset_rr_ain_ready", rr_ready, 0);
        check("reset_fx_ain_ready", fx_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_rr_valid", rr_ovalid, 0);
        check("reset_held_r3_ain_ready", r3_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Concurrent streams: fixed starves port 3, RR rotates 0..3 and 0..2.
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("fx_ain_ready_%0d", k), fx_ready, 4'b0010);
            check($sformatf("rr_ain_ready_%0d", k), rr_ready, 32'(1) << seq4[k]);
            check($sformatf("r3_ain_ready_%0d", k), r3_ready, 32'(1) << seq3[k]);
            @(posedge clk);
            #1;
            check($sformatf("fx_port_index_%0d", k), fx_idx, 1);
            check($sformatf("fx_aout_%0d", k), fx_aout, 8'h11);
            check($sformatf("fx_aout_valid_%0d", k), fx_ovalid, 1);
            check($sformatf("rr_port_index_%0d", k), rr_idx, seq4[k]);
            check($sformatf("rr_aout_%0d", k), rr_aout, 8'h10 + seq4[k]);
            check($sformatf("rr_aout_valid_%0d", k), rr_ovalid, 1);
            check($sformatf("r3_port_index_%0d", k), r3_idx, seq3[k]);
            check($sformatf("r3_aout_%0d", k), r3_aout, 8'h08 + seq3[k]);
            check($sformatf("r3_rr_ptr_%0d", k), dut_r3.rr_ptr, ptr3[k]);
        end

        // Stall: port 0 data held for five cycles, no port accepted.
        rr_oready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall_ain_ready_%0d", k), rr_ready, 0);
            @(posedge clk);
            #1;
            check($sformatf("stall_aout_%0d", k), rr_aout, 8'h10);
            check($sformatf("stall_port_index_%0d", k), rr_idx, 0);
            check($sformatf("stall_aout_valid_%0d", k), rr_ovalid, 1);
        end

        // Release: drain and load in the same cycle, pointer resumes at port 1.
        rr_oready = 1'b1;
        #1;
        check("unstall_ain_ready", rr_ready, 4'b0010);
        @(posedge clk);
        #1;
        check("unstall_port_index", rr_idx, 1);
        check("unstall_aout", rr_aout, 8'h11);
        check("unstall_aout_valid", rr_ovalid, 1);

        // Drain with nothing pending empties the register.
        rr_valid = 4'b0000;
        @(posedge clk);
        #1;
        check("drain_aout_valid", rr_ovalid, 0);

        // Load port 2 (pointer is 2), then reset mid-cycle with data held.
        rr_valid  = 4'b1111;
        rr_oready = 1'b0;
        @(posedge clk);
        #1;
        check("preload_port_index", rr_idx, 2);
        check("preload_aout_valid", rr_ovalid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_aout_valid", rr_ovalid, 0);
        check("async_reset_aout", rr_aout, 0);
        check("async_reset_port_index", rr_idx, 0);
        check("async_reset_ain_ready", rr_ready, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rr_oready = 1'b1;
        #1;
        check("post_reset_ain_ready", rr_ready, 4'b0001);
        @(posedge clk);
        #1;
        check("post_reset_port_index", rr_idx, 0);
        check("post_reset_aout", rr_aout, 8'h10);
        check("post_reset_aout_valid", rr_ovalid, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
